program_loader: RTL and testbench
=================================

# program_loader

Boot-time writer for the 1024 x 18-bit instruction memory that the CPU core fetches from. It accepts a byte stream over a valid/ready handshake, frames it into a length header, packed 18-bit instruction words and a checksum, and writes each word into instruction memory at consecutive addresses. While a load is in progress it holds the CPU core in reset through `cpu_hold`.

## Interface
- `BASE_ADDR`, default 0: first instruction-memory address written. Width is 10 bits.
- `TIMEOUT`, default 65535: maximum idle cycles allowed between accepted bytes during a load. A value of 0 disables the timeout.
- `clk`  in  1  clock. All state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle. A byte transfers when `in_valid` and `in_ready` are both high on a clock edge.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  10  write address.
- `imem_wdata`  out  18  write data.
- `cpu_hold`  out  1  holds the CPU in reset while a load is active.
- `busy`  out  1  load in progress.
- `done`  out  1  last load completed and the checksum matched. Sticky until the next `start`.
- `error`  out  1  last load failed. Sticky until the next `start`.
- `err_code`  out  2  failure cause: 0 none, 1 bad length, 2 checksum mismatch, 3 timeout.

## Operation
- **Frame format:** LEN_HI, LEN_LO, then N x (B0, B1, B2), then CSUM.
  - N = {LEN_HI[2:0], LEN_LO}, an 11-bit count.
  - LEN_HI[7:3] is ignored.
- **Word packing:** word = {B0[1:0], B1, B2}. B0[7:2] is ignored.
- **Checksum:** CSUM must equal the 8-bit XOR of every byte before it, header bytes included.
- **States:** IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CSUM, DONE, ERROR.
  - IDLE, DONE or ERROR + `start` -> LEN_HI. This clears `done`, `error`, `err_code`, the running XOR and the word counter.
  - LEN_HI -> LEN_LO on byte.
  - LEN_LO, on byte:
    - N = 0 -> CSUM.
    - N > 1024 -> ERROR with code 1.
    - otherwise -> B0.
  - B0 -> B1 -> B2 on byte.
  - B2 -> WRITE on byte.
  - WRITE lasts one cycle and pulses `imem_we`. It then increments the word counter and goes to B0, or to CSUM once N words have been written.
  - CSUM, on byte: go to DONE on match, or to ERROR with code 2 on mismatch.
- **Handshake:** `in_ready` is high only in LEN_HI, LEN_LO, B0, B1, B2 and CSUM. It is low in WRITE, IDLE, DONE and ERROR.
- **Addressing:** `imem_addr` = BASE_ADDR + word counter, wrapping mod 1024. BASE_ADDR = 1000 with N = 1024 wraps to address 0 after 1023.
- **Outputs:** `cpu_hold` and `busy` are high in every state except IDLE, DONE and ERROR.
- **Timeout:** an idle counter resets on every accepted byte and on `start`. It increments in any `in_ready` state without a transfer. Reaching TIMEOUT goes to ERROR with code 3.
- **Ignored start:** `start` during a load is ignored.
- **Partial loads:** words already written are not rolled back on error or reset.

## Timing
- **Reset:** asynchronous; enters IDLE. All outputs are 0; `imem_addr` and `imem_wdata` are 0.
- **Start latency:** `start` at edge k gives `in_ready` = 1 and `cpu_hold` = 1 from cycle k+1.
- **Write latency:** B2 accepted at edge k -> `imem_we` = 1 in cycle k+1, with address and data stable. `in_ready` is low in cycle k+1 and high again in k+2.
- **Throughput:** 4 cycles per word at full rate. A complete load takes 3 + 4N cycles.
- **Completion:** CSUM accepted at edge k -> in cycle k+1, `done` or `error` is set and `cpu_hold` and `busy` are low.
- **Reset mid-load:** immediately deasserts `imem_we` and `cpu_hold`.
- **Back-pressure:** `in_valid` may drop at any time; the state holds and only the timeout counter advances.

## Structure
- Shared package holds:
  - the state enum;
  - `ERR_NONE`, `ERR_LEN`, `ERR_CSUM`, `ERR_TIMEOUT`;
  - `IMEM_DEPTH` = 1024;
  - `INSTR_W` = 18.
- The CPU-side instruction memory gains a write port driven by `imem_*`.
- The CPU reset is `reset | cpu_hold`.
- A single flat module; no sub-module.

## Test plan
- **Normal load:** BASE_ADDR = 0, N = 2, words 0x2_1234 and 0x0_00FF, correct CSUM. Expect writes (0, 0x21234) and (1, 0x000FF), then `done` = 1, `error` = 0, `cpu_hold` low after CSUM.
- **Empty load:** N = 0, then CSUM = 0x00 (XOR of 0x00, 0x00). Expect `done` = 1 and no `imem_we` pulse.
- **Bad length:** LEN_HI = 0x04, LEN_LO = 0x01 (N = 1025). Expect `error` = 1, `err_code` = 1, no writes.
- **Checksum mismatch:** N = 1 with CSUM inverted. Expect one write, then `error` = 1 with `err_code` = 2.
- **Back-pressure and wrap:** `in_valid` toggled randomly, BASE_ADDR = 1023, N = 2. Expect addresses 1023 then 0, and `in_ready` low in each WRITE cycle.
- **Timeout and reset:** TIMEOUT = 8, stall after B1. Expect `error`, `err_code` = 3 at the 8th idle cycle. A second run with `reset` asserted mid-word returns to IDLE with all outputs 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package program_loader_pkg;

  localparam int IMEM_DEPTH = 1024;
  localparam int INSTR_W    = 18;
  localparam int ADDR_W     = 10;
  localparam int CNT_W      = 11;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  function automatic logic takes_byte(state_e s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) ||
           (s == S_B0) || (s == S_B1) ||
           (s == S_B2) || (s == S_CSUM);
  endfunction

  function automatic logic is_rest(state_e s);
    return (s == S_IDLE) || (s == S_DONE) ||
           (s == S_ERROR);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Frames a byte stream into 18-bit instruction words and writes
// them to instruction memory while holding the CPU in reset.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [9:0]  BASE_ADDR = 10'd0,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [17:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;
  localparam logic [CNT_W-1:0] MAX_LEN =
    CNT_W'(IMEM_DEPTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           xor_q, xor_d;
  logic [1:0]           b0_q, b0_d;
  logic [7:0]           b1_q, b1_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic [31:0]          idle_q, idle_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [1:0]           err_q, err_d;

  logic                 ready;
  logic                 fire;
  logic                 idle_last;
  logic [CNT_W-1:0]     n_len;
  logic [CNT_W-1:0]     cnt_inc;

  assign ready     = takes_byte(state_q);
  assign fire      = ready && in_valid;
  assign idle_last = (TIMEOUT != 0) &&
                     (idle_q == TO_LAST);
  assign n_len     = {len_q[10:8], in_data};
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idle_d  = '0;
    done_d  = done_q;
    error_d = error_q;
    err_d   = err_q;

    if (ready && !fire) idle_d = idle_q + 32'd1;
    // The checksum byte itself is not folded in.
    if (fire && state_q != S_CSUM)
      xor_d = xor_q ^ in_data;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          error_d = 1'b0;
          err_d   = ERR_NONE;
          xor_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (fire) begin
          len_d   = {in_data[2:0], 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (fire) begin
          len_d = n_len;
          if (n_len == '0) begin
            state_d = S_CSUM;
          end else if (n_len > MAX_LEN) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            err_d   = ERR_LEN;
          end else begin
            state_d = S_B0;
          end
        end
      end
      S_B0: begin
        if (fire) begin
          b0_d    = in_data[1:0];
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (fire) begin
          b1_d    = in_data;
          state_d = S_B2;
        end
      end
      S_B2: begin
        if (fire) begin
          wdata_d = {b0_q, b1_q, in_data};
          addr_d  = BASE_ADDR + cnt_q[ADDR_W-1:0];
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? S_CSUM : S_B0;
      end
      S_CSUM: begin
        if (fire) begin
          if (in_data == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ready && !fire && idle_last) begin
      state_d = S_ERROR;
      error_d = 1'b1;
      err_d   = ERR_TIMEOUT;
      idle_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = ready;
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = !is_rest(state_q);
  assign busy       = !is_rest(state_q);
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (base 0 with a
// short timeout, base 1023 for wrap), write scoreboard at negedge.
`timescale 1ns/1ps
module tb_program_loader;

  typedef struct packed {
    logic [9:0]  a;
    logic [17:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        sel;

  logic        rdy_a, we_a, hold_a, busy_a;
  logic        done_a, err_a;
  logic [9:0]  addr_a;
  logic [17:0] wdata_a;
  logic [1:0]  code_a;
  logic        rdy_b, we_b, hold_b, busy_b;
  logic        done_b, err_b;
  logic [9:0]  addr_b;
  logic [17:0] wdata_b;
  logic [1:0]  code_b;

  int n_chk = 0;
  int n_fail = 0;
  wr_t exp_q[$];
  logic [17:0] words [0:3];

  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(10'd0), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_a), .imem_we(we_a),
    .imem_addr(addr_a), .imem_wdata(wdata_a),
    .cpu_hold(hold_a), .busy(busy_a),
    .done(done_a), .error(err_a), .err_code(code_a)
  );

  program_loader #(.BASE_ADDR(10'd1023)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_b), .imem_we(we_b),
    .imem_addr(addr_b), .imem_wdata(wdata_b),
    .cpu_hold(hold_b), .busy(busy_b),
    .done(done_b), .error(err_b), .err_code(code_b)
  );

  logic       c_rdy, c_hold, c_busy, c_done, c_err, c_we;
  logic [1:0] c_code;
  assign c_rdy  = sel ? rdy_b  : rdy_a;
  assign c_hold = sel ? hold_b : hold_a;
  assign c_busy = sel ? busy_b : busy_a;
  assign c_done = sel ? done_b : done_a;
  assign c_err  = sel ? err_b  : err_a;
  assign c_code = sel ? code_b : code_a;
  assign c_we   = sel ? we_b   : we_a;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the queue head.
  always @(negedge clk) begin
    if (!reset && (we_a || we_b)) begin
      wr_t got, e;
      got.a = we_b ? addr_b : addr_a;
      got.d = we_b ? wdata_b : wdata_a;
      chk("we_expected", 32'(exp_q.size() != 0), 1);
      chk("ready_in_write",
          32'(we_b ? rdy_b : rdy_a), 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(got.a), 32'(e.a));
        chk("wr_data", 32'(got.d), 32'(e.d));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send(input logic [7:0] b, input bit bp);
    int n = 0;
    if (bp) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!c_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_bound", 32'(c_rdy), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk("start_ready", 32'(c_rdy), 1);
    chk("start_hold", 32'(c_hold), 1);
    chk("start_done_clr", 32'(c_done), 0);
    chk("start_err_clr", 32'(c_err), 0);
  endtask

  task automatic frame(input int n, input bit bad,
                       input bit bp);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [10:0] nn;
    logic [9:0]  base;
    logic [17:0] w;
    wr_t         e;
    x    = 8'h00;
    nn   = 11'(n);
    base = sel ? 10'd1023 : 10'd0;
    b = {5'b10101, nn[10:8]};
    send(b, bp); x ^= b;
    b = nn[7:0];
    send(b, bp); x ^= b;
    for (int i = 0; i < n; i++) begin
      w = words[i];
      b = {6'b110011, w[17:16]};
      send(b, bp); x ^= b;
      b = w[15:8];
      send(b, bp); x ^= b;
      e.a = base + 10'(i);
      e.d = w;
      exp_q.push_back(e);
      b = w[7:0];
      send(b, bp); x ^= b;
    end
    send(bad ? ~x : x, bp);
  endtask

  task automatic chk_end(input string tag, input bit ok,
                         input logic [1:0] code);
    chk({tag, "_done"}, 32'(c_done), 32'(ok));
    chk({tag, "_error"}, 32'(c_err), 32'(!ok));
    chk({tag, "_code"}, 32'(c_code), 32'(code));
    chk({tag, "_hold"}, 32'(c_hold), 0);
    chk({tag, "_busy"}, 32'(c_busy), 0);
    chk({tag, "_ready"}, 32'(c_rdy), 0);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    reset    = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    sel      = 1'b0;
    words[0] = 18'h21234;
    words[1] = 18'h000FF;
    words[2] = 18'h3ABCD;
    words[3] = 18'h10001;
    repeat (2) @(negedge clk);

    chk("rst_we", 32'(we_a), 0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_wdata", 32'(wdata_a), 0);
    chk("rst_hold", 32'(hold_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_ready", 32'(rdy_a), 0);
    chk("rst_flags", 32'({done_a, err_a, code_a}), 0);
    chk("rst_addr_b", 32'(addr_b), 0);
    reset = 1'b0;
    @(negedge clk);

    // Normal load, two words.
    do_start();
    frame(2, 1'b0, 1'b0);
    chk_end("normal", 1'b1, 2'd0);

    // Empty load: CSUM of the two header bytes.
    do_start();
    frame(0, 1'b0, 1'b0);
    chk_end("empty", 1'b1, 2'd0);

    // Length 1025 rejected after LEN_LO.
    do_start();
    send(8'h04, 1'b0);
    send(8'h01, 1'b0);
    chk_end("badlen", 1'b0, 2'd1);

    // Checksum mismatch after one word.
    words[0] = 18'h3ABCD;
    do_start();
    frame(1, 1'b1, 1'b0);
    chk_end("csum", 1'b0, 2'd2);

    // Back-pressure and address wrap on the base-1023 instance.
    sel = 1'b1;
    words[0] = 18'h21234;
    words[1] = 18'h000FF;
    do_start();
    frame(2, 1'b0, 1'b1);
    chk_end("wrap", 1'b1, 2'd0);
    sel = 1'b0;

    // Timeout: stall in B2 for 8 idle cycles.
    do_start();
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h12, 1'b0);
    repeat (7) @(negedge clk);
    chk("to_pre_busy", 32'(busy_a), 1);
    chk("to_pre_err", 32'(err_a), 0);
    @(negedge clk);
    chk("to_err", 32'(err_a), 1);
    chk("to_code", 32'(code_a), 3);
    chk("to_hold", 32'(hold_a), 0);

    // Reset mid-word after one word has been written.
    do_start();
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h01, 1'b0);
    send(8'h55, 1'b0);
    exp_q.push_back('{a: 10'd0, d: 18'h155AA});
    send(8'hAA, 1'b0);
    send(8'h02, 1'b0);
    send(8'h34, 1'b0);
    chk("mid_busy", 32'(busy_a), 1);
    chk("mid_q_empty", 32'(exp_q.size()), 0);
    reset = 1'b1;
    #1;
    chk("mrst_we", 32'(we_a), 0);
    chk("mrst_hold", 32'(hold_a), 0);
    chk("mrst_busy", 32'(busy_a), 0);
    chk("mrst_ready", 32'(rdy_a), 0);
    chk("mrst_addr", 32'(addr_a), 0);
    chk("mrst_wdata", 32'(wdata_a), 0);
    chk("mrst_flags", 32'({done_a, err_a, code_a}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
